// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - Shared widths, type codes and pointer helper for the reorder buffer
package reorder_buffer_pkg;
    localparam int ROB_SIZE = 15;
    localparam int ROB_ID_W = 4;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int PC_W     = 32;

    localparam logic [ROB_ID_W-1:0] RENAMED_ZERO = '0;
    localparam logic [ROB_ID_W-1:0] ROB_LAST     = ROB_ID_W'(ROB_SIZE);
    localparam logic [ROB_ID_W-1:0] ROB_FIRST    = ROB_ID_W'(1);

    typedef enum logic [1:0] {
        ROB_TYPE_REG = 2'd0,
        ROB_TYPE_BR  = 2'd1,
        ROB_TYPE_ST  = 2'd2
    } rob_type_e;

    // IDs run 1..ROB_SIZE; 0 is reserved for "not renamed".
    function automatic logic [ROB_ID_W-1:0] next_id(input logic [ROB_ID_W-1:0] id);
        return (id == ROB_LAST) ? ROB_FIRST : id + ROB_FIRST;
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - Dispatch, CDB, commit and query signals of the reorder buffer
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                dsp_valid;
    logic [1:0]          dsp_type;
    logic [REG_W-1:0]    dsp_rd;
    logic [PC_W-1:0]     dsp_alt_pc;
    logic [ROB_ID_W-1:0] alloc_id;
    logic                rob_full;

    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_id;
    logic [DATA_W-1:0]   cdb_value;
    logic                cdb_mispredict;

    logic                rob_has_res;
    logic [DATA_W-1:0]   result_from_rob;
    logic [REG_W-1:0]    regidx_from_rob;
    logic [ROB_ID_W-1:0] regalias_from_rob;
    logic                store_commit;
    logic [ROB_ID_W-1:0] store_commit_id;
    logic                rollback_signal;
    logic [PC_W-1:0]     rollback_pc;

    logic [ROB_ID_W-1:0] qry1_id;
    logic                qry1_ready;
    logic [DATA_W-1:0]   qry1_value;
    logic [ROB_ID_W-1:0] qry2_id;
    logic                qry2_ready;
    logic [DATA_W-1:0]   qry2_value;

    modport master (
        output dsp_valid, dsp_type, dsp_rd, dsp_alt_pc,
        output cdb_valid, cdb_id, cdb_value, cdb_mispredict,
        output qry1_id, qry2_id,
        input  alloc_id, rob_full,
        input  rob_has_res, result_from_rob, regidx_from_rob, regalias_from_rob,
        input  store_commit, store_commit_id, rollback_signal, rollback_pc,
        input  qry1_ready, qry1_value, qry2_ready, qry2_value
    );

    modport slave (
        input  dsp_valid, dsp_type, dsp_rd, dsp_alt_pc,
        input  cdb_valid, cdb_id, cdb_value, cdb_mispredict,
        input  qry1_id, qry2_id,
        output alloc_id, rob_full,
        output rob_has_res, result_from_rob, regidx_from_rob, regalias_from_rob,
        output store_commit, store_commit_id, rollback_signal, rollback_pc,
        output qry1_ready, qry1_value, qry2_ready, qry2_value
    );
endinterface

// File: rtl/rob_query_port.sv
// rtl/rob_query_port.sv - Combinational operand lookup into the reorder buffer with same-cycle CDB forward
module rob_query_port
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_ID_W-1:0]            id,
    input  logic [ROB_SIZE:0]              ready_vec,
    input  logic [ROB_SIZE:0][DATA_W-1:0]  value_vec,
    input  logic                           cdb_valid,
    input  logic [ROB_ID_W-1:0]            cdb_id,
    input  logic [DATA_W-1:0]              cdb_value,
    output logic                           ready,
    output logic [DATA_W-1:0]              value
);
    always_comb begin
        ready = 1'b0;
        value = '0;
        if (id != RENAMED_ZERO) begin
            if (cdb_valid && (cdb_id == id)) begin
                ready = 1'b1;
                value = cdb_value;
            end else begin
                ready = ready_vec[id];
                value = value_vec[id];
            end
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - Circular reorder buffer: allocate, CDB writeback, in-order commit, rollback
// Optional operand query ports under `ROB_OPERAND_QUERY_EN.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    reorder_buffer_if.slave bus
);
    logic [ROB_SIZE:0]             busy_q, ready_q, mis_q;
    logic [ROB_SIZE:0][1:0]        type_q;
    logic [ROB_SIZE:0][REG_W-1:0]  rd_q;
    logic [ROB_SIZE:0][DATA_W-1:0] val_q;
    logic [ROB_SIZE:0][PC_W-1:0]   pc_q;
    logic [ROB_ID_W-1:0]           head_q, tail_q, count_q;

    logic                has_res_q, store_q, rollback_q;
    logic [DATA_W-1:0]   result_q;
    logic [REG_W-1:0]    regidx_q;
    logic [ROB_ID_W-1:0] regalias_q, store_id_q;
    logic [PC_W-1:0]     rollback_pc_q;

    logic full, head_commit, flush, do_alloc, do_wb;

    // The cycle showing rollback_signal belongs to the flushed machine: ignore its dispatch/CDB.
    assign full        = (count_q == ROB_LAST);
    assign head_commit = busy_q[head_q] && ready_q[head_q];
    assign flush       = head_commit && (type_q[head_q] == ROB_TYPE_BR) && mis_q[head_q];
    assign do_alloc    = bus.dsp_valid && !full && !rollback_q;
    assign do_wb       = bus.cdb_valid && busy_q[bus.cdb_id] && !rollback_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q        <= '0;
            ready_q       <= '0;
            mis_q         <= '0;
            type_q        <= '0;
            rd_q          <= '0;
            val_q         <= '0;
            pc_q          <= '0;
            head_q        <= ROB_FIRST;
            tail_q        <= ROB_FIRST;
            count_q       <= '0;
            has_res_q     <= 1'b0;
            store_q       <= 1'b0;
            rollback_q    <= 1'b0;
            result_q      <= '0;
            regidx_q      <= '0;
            regalias_q    <= '0;
            store_id_q    <= '0;
            rollback_pc_q <= '0;
        end else if (rdy) begin
            has_res_q  <= 1'b0;
            store_q    <= 1'b0;
            rollback_q <= 1'b0;
            if (flush) begin
                rollback_q    <= 1'b1;
                rollback_pc_q <= pc_q[head_q];
                busy_q        <= '0;
                ready_q       <= '0;
                head_q        <= ROB_FIRST;
                tail_q        <= ROB_FIRST;
                count_q       <= '0;
            end else begin
                if (do_wb) begin
                    ready_q[bus.cdb_id] <= 1'b1;
                    val_q[bus.cdb_id]   <= bus.cdb_value;
                    mis_q[bus.cdb_id]   <= bus.cdb_mispredict;
                end
                if (head_commit) begin
                    case (type_q[head_q])
                        ROB_TYPE_REG: begin
                            has_res_q  <= 1'b1;
                            result_q   <= val_q[head_q];
                            regidx_q   <= rd_q[head_q];
                            regalias_q <= head_q;
                        end
                        ROB_TYPE_ST: begin
                            store_q    <= 1'b1;
                            store_id_q <= head_q;
                        end
                        default: ;
                    endcase
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= next_id(head_q);
                end
                if (do_alloc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    mis_q[tail_q]   <= 1'b0;
                    type_q[tail_q]  <= bus.dsp_type;
                    rd_q[tail_q]    <= bus.dsp_rd;
                    pc_q[tail_q]    <= bus.dsp_alt_pc;
                    tail_q          <= next_id(tail_q);
                end
                count_q <= count_q + ROB_ID_W'(do_alloc) - ROB_ID_W'(head_commit);
            end
        end
    end

    assign bus.alloc_id          = tail_q;
    assign bus.rob_full          = full;
    assign bus.rob_has_res       = has_res_q;
    assign bus.result_from_rob   = result_q;
    assign bus.regidx_from_rob   = regidx_q;
    assign bus.regalias_from_rob = regalias_q;
    assign bus.store_commit      = store_q;
    assign bus.store_commit_id   = store_id_q;
    assign bus.rollback_signal   = rollback_q;
    assign bus.rollback_pc       = rollback_pc_q;

`ifdef ROB_OPERAND_QUERY_EN
    rob_query_port u_qry1 (
        .id        (bus.qry1_id),
        .ready_vec (ready_q),
        .value_vec (val_q),
        .cdb_valid (bus.cdb_valid),
        .cdb_id    (bus.cdb_id),
        .cdb_value (bus.cdb_value),
        .ready     (bus.qry1_ready),
        .value     (bus.qry1_value)
    );
    rob_query_port u_qry2 (
        .id        (bus.qry2_id),
        .ready_vec (ready_q),
        .value_vec (val_q),
        .cdb_valid (bus.cdb_valid),
        .cdb_id    (bus.cdb_id),
        .cdb_value (bus.cdb_value),
        .ready     (bus.qry2_ready),
        .value     (bus.qry2_value)
    );
`else
    logic unused_qry;
    assign unused_qry     = ^{bus.qry1_id, bus.qry2_id};
    assign bus.qry1_ready = 1'b0;
    assign bus.qry1_value = '0;
    assign bus.qry2_ready = 1'b0;
    assign bus.qry2_value = '0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - Directed bench for reorder_buffer with a queue-based reference model
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   tests = 0;
    int   fails = 0;
    int   store_seen = 0;

    reorder_buffer_if bus();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
        bit          done;
        bit          mis;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_tail;
    bit          e_has_res, e_store, e_rb;
    logic [31:0] e_result, e_rb_pc;
    logic [4:0]  e_regidx;
    logic [3:0]  e_alias, e_store_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail    = 4'd1;
        e_has_res = 0;
        e_store   = 0;
        e_rb      = 0;
    endtask

    // Queue model: q[0] is the oldest instruction; a flush empties the queue.
    task automatic model_step();
        bit   flushed = 0;
        bit   was_rb  = e_rb;
        int   n0      = q.size();
        ent_t e;
        e_has_res = 0;
        e_store   = 0;
        e_rb      = 0;
        if (n0 > 0 && q[0].done) begin
            case (q[0].typ)
                2'd0: begin
                    e_has_res = 1; e_result = q[0].val; e_regidx = q[0].rd; e_alias = q[0].id;
                end
                2'd2: begin
                    e_store = 1; e_store_id = q[0].id;
                end
                default: if (q[0].mis) begin
                    e_rb = 1; e_rb_pc = q[0].pc; flushed = 1;
                end
            endcase
            if (flushed) begin
                q.delete();
                m_tail = 4'd1;
            end else begin
                void'(q.pop_front());
            end
        end
        if (!flushed && !was_rb) begin
            if (bus.cdb_valid)
                foreach (q[i])
                    if (q[i].id == bus.cdb_id) begin
                        q[i].done = 1; q[i].val = bus.cdb_value; q[i].mis = bus.cdb_mispredict;
                    end
            if (bus.dsp_valid && n0 < 15) begin
                e.id = m_tail; e.typ = bus.dsp_type; e.rd = bus.dsp_rd; e.pc = bus.dsp_alt_pc;
                e.val = '0; e.done = 0; e.mis = 0;
                q.push_back(e);
                m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else if (rdy) model_step();
    end

`ifdef ROB_OPERAND_QUERY_EN
    function automatic void m_query(input logic [3:0] id, output bit r, output logic [31:0] v);
        r = 0;
        v = '0;
        if (id == 4'd0) return;
        if (bus.cdb_valid && bus.cdb_id == id) begin
            r = 1; v = bus.cdb_value; return;
        end
        foreach (q[i])
            if (q[i].id == id && q[i].done) begin
                r = 1; v = q[i].val;
            end
    endfunction
`endif

    always @(negedge clk) begin
`ifdef ROB_OPERAND_QUERY_EN
        bit          qr;
        logic [31:0] qv;
`endif
        if (rdy && bus.store_commit) store_seen++;
        check("alloc_id", bus.alloc_id, m_tail);
        check("rob_full", bus.rob_full, q.size() == 15);
        check("rob_has_res", bus.rob_has_res, e_has_res);
        if (e_has_res) begin
            check("result_from_rob", bus.result_from_rob, e_result);
            check("regidx_from_rob", bus.regidx_from_rob, e_regidx);
            check("regalias_from_rob", bus.regalias_from_rob, e_alias);
        end
        check("store_commit", bus.store_commit, e_store);
        if (e_store) check("store_commit_id", bus.store_commit_id, e_store_id);
        check("rollback_signal", bus.rollback_signal, e_rb);
        if (e_rb) check("rollback_pc", bus.rollback_pc, e_rb_pc);
`ifdef ROB_OPERAND_QUERY_EN
        m_query(bus.qry1_id, qr, qv);
        check("qry1_ready", bus.qry1_ready, qr);
        if (qr) check("qry1_value", bus.qry1_value, qv);
        m_query(bus.qry2_id, qr, qv);
        check("qry2_ready", bus.qry2_ready, qr);
        if (qr) check("qry2_value", bus.qry2_value, qv);
`else
        check("qry1_ready_tied", bus.qry1_ready, 0);
        check("qry2_value_tied", bus.qry2_value, 0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dsp_valid = 0; bus.dsp_type = 0; bus.dsp_rd = 0; bus.dsp_alt_pc = 0;
        bus.cdb_valid = 0; bus.cdb_id = 0; bus.cdb_value = 0; bus.cdb_mispredict = 0;
        bus.qry1_id = 0; bus.qry2_id = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1;
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic dispatch(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc);
        bus.dsp_valid = 1; bus.dsp_type = t; bus.dsp_rd = rd; bus.dsp_alt_pc = pc;
        step();
        bus.dsp_valid = 0;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic mis);
        bus.cdb_valid = 1; bus.cdb_id = id; bus.cdb_value = v; bus.cdb_mispredict = mis;
        step();
        bus.cdb_valid = 0; bus.cdb_mispredict = 0;
    endtask

    initial begin
        idle_inputs();
        rdy = 1;
        rst = 0;
        step();
        check("reset_alloc_id", bus.alloc_id, 1);
        check("reset_rob_full", bus.rob_full, 0);
        check("reset_pulses", {bus.rob_has_res, bus.store_commit, bus.rollback_signal}, 0);
        check("reset_rollback_pc", bus.rollback_pc, 0);
        check("reset_result", {bus.result_from_rob, bus.regidx_from_rob}, 0);
        rst = 1;

        // Single REG instruction: dispatch N, CDB N+1, commit visible N+3.
        dispatch(2'd0, 5'd5, 32'h0);
        check("t1_alloc_next", bus.alloc_id, 2);
        cdb(4'd1, 32'h1234, 0);
        check("t1_no_early_commit", bus.rob_has_res, 0);
        step();
        check("t1_has_res", bus.rob_has_res, 1);
        check("t1_regidx", bus.regidx_from_rob, 5);
        check("t1_value", bus.result_from_rob, 32'h1234);
        check("t1_alias", bus.regalias_from_rob, 1);
        step();
        check("t1_pulse_one_cycle", bus.rob_has_res, 0);

        // Fill all entries, overflow dispatch ignored, wrap of the tail.
        do_reset();
        for (int i = 1; i <= 15; i++) dispatch(2'd0, 5'(i), 32'h0);
        check("t2_full", bus.rob_full, 1);
        check("t2_alloc_wrapped", bus.alloc_id, 1);
        dispatch(2'd0, 5'd20, 32'h0);
        check("t2_overflow_full", bus.rob_full, 1);
        check("t2_overflow_alloc", bus.alloc_id, 1);
        cdb(4'd1, 32'h1, 0);
        step();
        check("t2_commit_alias", bus.regalias_from_rob, 1);
        check("t2_not_full", bus.rob_full, 0);
        dispatch(2'd0, 5'd21, 32'h0);
        check("t2_refull", bus.rob_full, 1);
        check("t2_alloc_after", bus.alloc_id, 2);

        // Out-of-order writeback, in-order commit.
        do_reset();
        for (int i = 0; i < 3; i++) dispatch(2'd0, 5'(10 + i), 32'h0);
        cdb(4'd3, 32'h33, 0);
        cdb(4'd2, 32'h22, 0);
        cdb(4'd1, 32'h11, 0);
        step();
        check("t3_first", bus.regalias_from_rob, 1);
        check("t3_first_val", bus.result_from_rob, 32'h11);
        step();
        check("t3_second", bus.regalias_from_rob, 2);
        step();
        check("t3_third", bus.regalias_from_rob, 3);
        check("t3_third_rd", bus.regidx_from_rob, 12);
        step();
        check("t3_drained", bus.rob_has_res, 0);

        // Mispredicted branch behind a REG op.
        do_reset();
        dispatch(2'd0, 5'd7, 32'h0);
        dispatch(2'd1, 5'd0, 32'h100);
        dispatch(2'd2, 5'd0, 32'h0);
        cdb(4'd1, 32'hAA, 0);
        cdb(4'd2, 32'h0, 1);
        check("t4_reg_commit", bus.regalias_from_rob, 1);
        check("t4_reg_pulse", bus.rob_has_res, 1);
        step();
        check("t4_rollback", bus.rollback_signal, 1);
        check("t4_rollback_pc", bus.rollback_pc, 32'h100);
        check("t4_alloc_reset", bus.alloc_id, 1);
        check("t4_br_no_reg", bus.rob_has_res, 0);
        bus.dsp_valid = 1; bus.dsp_type = 2'd0; bus.dsp_rd = 5'd9;
        cdb(4'd3, 32'h55, 0);
        bus.dsp_valid = 0;
        check("t4_dispatch_ignored", bus.alloc_id, 1);
        check("t4_rollback_once", bus.rollback_signal, 0);
        dispatch(2'd0, 5'd3, 32'h0);
        repeat (3) step();
        check("t4_no_stale_commit", bus.rob_has_res, 0);

        // Pulse held across a 3-cycle freeze, seen once.
        do_reset();
        dispatch(2'd2, 5'd0, 32'h0);
        cdb(4'd1, 32'h0, 0);
        step();
        check("t5_store", bus.store_commit, 1);
        check("t5_store_id", bus.store_commit_id, 1);
        rdy = 0;
        store_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_store_held", bus.store_commit, 1);
        end
        rdy = 1;
        step();
        check("t5_store_released", bus.store_commit, 0);
        check("t5_store_seen_once", store_seen, 1);

        // Asynchronous reset between clock edges.
        dispatch(2'd0, 5'd4, 32'h0);
        check("t6_alloc_before", bus.alloc_id, 3);
        #2 rst = 0;
        #1;
        check("t6_async_alloc", bus.alloc_id, 1);
        step();
        rst = 1;

`ifdef ROB_OPERAND_QUERY_EN
        do_reset();
        for (int i = 0; i < 4; i++) dispatch(2'd0, 5'(i), 32'h0);
        bus.qry1_id = 4'd4; bus.qry2_id = 4'd0;
        bus.cdb_valid = 1; bus.cdb_id = 4'd4; bus.cdb_value = 32'h77;
        #1;
        check("t7_fwd_ready", bus.qry1_ready, 1);
        check("t7_fwd_value", bus.qry1_value, 32'h77);
        check("t7_id0_ready", bus.qry2_ready, 0);
        step();
        bus.cdb_valid = 0;
        #1;
        check("t7_entry_ready", bus.qry1_ready, 1);
        check("t7_entry_value", bus.qry1_value, 32'h77);
        step();
`else
        do_reset();
        dispatch(2'd0, 5'd1, 32'h0);
        bus.qry1_id = 4'd1;
        bus.cdb_valid = 1; bus.cdb_id = 4'd1; bus.cdb_value = 32'h77;
        #1;
        check("t7_query_tied_ready", bus.qry1_ready, 0);
        check("t7_query_tied_value", bus.qry1_value, 0);
        step();
        bus.cdb_valid = 0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
